// File: rtl/bus_source_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bus_sel_pkg
// Shared constants for the datapath bus source selector: the legacy source
// index map, the arbitration mode enum and the default number of sources.
// No ports (package).
// ----------------------------------------------------------------------------
package bus_sel_pkg;

  // Legacy bus source map (bit index into the request vector)
  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_COUT   = 23;

  localparam int DEFAULT_N_SRC = 32;

  typedef enum logic {
    FIXED = 1'b0,
    RR    = 1'b1
  } bus_sel_mode_e;

endpackage

// File: rtl/bus_source_arbiter_if.sv
// ----------------------------------------------------------------------------
// bus_source_arbiter_if
// Bundles the control-side request/qualifier signals and the registered
// select/status outputs of the bus source arbiter.
//   master : control unit side (drives req_in/sample/lock/err_clear)
//   slave  : arbiter side (drives sel_out/grant_oh/status)
// There is no valid/ready handshake: 'sample' qualifies req_in on each rising
// edge; outputs are registered and valid one cycle later.
// ----------------------------------------------------------------------------
interface bus_source_arbiter_if
  import bus_sel_pkg::*;
#(
  parameter int N_SRC = DEFAULT_N_SRC,
  parameter int CNT_W = 8
);
  localparam int SEL_W = $clog2(N_SRC);

  logic [N_SRC-1:0] req_in;
  logic             sample;
  logic             lock;
  logic             err_clear;
  logic [SEL_W-1:0] sel_out;
  logic [N_SRC-1:0] grant_oh;
  logic             sel_valid;
  logic             multi_drive;
  logic             contention_err;
  logic [CNT_W-1:0] contention_cnt;

  modport master (
    output req_in, sample, lock, err_clear,
    input  sel_out, grant_oh, sel_valid, multi_drive, contention_err, contention_cnt
  );

  modport slave (
    input  req_in, sample, lock, err_clear,
    output sel_out, grant_oh, sel_valid, multi_drive, contention_err, contention_cnt
  );

endinterface

// File: rtl/bus_source_arbiter_priority_pick.sv
// ----------------------------------------------------------------------------
// priority_pick
// Combinational circular scan of a request vector. Starting at i_start, it
// walks upward (DOWN=0) or downward (DOWN=1), wrapping modulo N_SRC, and
// returns the first set index.
//   i_req   : request vector
//   i_start : first index examined
//   o_idx   : first set index found (0 when none)
//   o_found : at least one request bit set
// ----------------------------------------------------------------------------
module priority_pick #(
  parameter int N_SRC = 32,
  parameter int SEL_W = $clog2(N_SRC),
  parameter bit DOWN  = 1'b0
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [SEL_W-1:0] i_start,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_found
);

  always_comb begin
    int               v_pos;
    logic [SEL_W-1:0] v_idx;
    v_pos   = 0;
    v_idx   = '0;
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (DOWN) begin
        v_pos = int'(i_start) - k;
        if (v_pos < 0) v_pos = v_pos + N_SRC;
      end else begin
        v_pos = int'(i_start) + k;
        if (v_pos >= N_SRC) v_pos = v_pos - N_SRC;
      end
      v_idx = v_pos[SEL_W-1:0];
      // Only the first hit in scan order counts
      if (!o_found && i_req[v_idx]) begin
        o_found = 1'b1;
        o_idx   = v_idx;
      end
    end
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// ----------------------------------------------------------------------------
// bus_source_arbiter
// Registered source selector for the shared datapath bus. Picks one of N_SRC
// drive requests (fixed priority, highest index wins, or round-robin), with
// grant locking and multi-driver contention detection/counting.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave modport of bus_source_arbiter_if
//             in : req_in, sample, lock, err_clear
//             out: sel_out, grant_oh, sel_valid, multi_drive,
//                  contention_err, contention_cnt (all flop outputs)
// Parameters: N_SRC sources, MODE 0=fixed / 1=round-robin, CNT_W counter width.
// ----------------------------------------------------------------------------
module bus_source_arbiter
  import bus_sel_pkg::*;
#(
  parameter int N_SRC = DEFAULT_N_SRC,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  bus_source_arbiter_if.slave bus
);

  localparam int               SEL_W    = $clog2(N_SRC);
  localparam bus_sel_mode_e    L_MODE   = (MODE == 1) ? RR : FIXED;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_SRC - 1);
  localparam logic [N_SRC-1:0] ONE_OH   = N_SRC'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [SEL_W-1:0] r_sel;
  logic [N_SRC-1:0] r_grant;
  logic             r_valid;
  logic             r_multi;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_last;

  logic [SEL_W-1:0] w_rr_start;
  logic [SEL_W-1:0] w_start;
  logic [SEL_W-1:0] w_idx;
  logic             w_found;
  logic             w_multi;
  logic             w_hold;

  // Round-robin starts one past the last grant; fixed priority always starts
  // at the top index and scans down.
  assign w_rr_start = (r_last == LAST_IDX) ? '0 : r_last + 1'b1;
  assign w_start    = (L_MODE == RR) ? w_rr_start : LAST_IDX;

  priority_pick #(
    .N_SRC (N_SRC),
    .SEL_W (SEL_W),
    .DOWN  (L_MODE == FIXED)
  ) u_pick (
    .i_req   (bus.req_in),
    .i_start (w_start),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  // Clearing the lowest set bit leaves something behind only if >1 bit set
  assign w_multi = |(bus.req_in & (bus.req_in - 1'b1));
  assign w_hold  = bus.lock && r_valid && bus.req_in[r_sel];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sel   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_last  <= LAST_IDX;
    end else begin
      if (bus.err_clear) begin
        r_err <= 1'b0;
        r_cnt <= '0;
      end
      if (bus.sample) begin
        r_multi <= w_multi;
        // A contention event on the same edge as a clear counts after it
        if (w_multi) begin
          r_err <= 1'b1;
          if (bus.err_clear)       r_cnt <= CNT_W'(1);
          else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        end
        if (w_hold) begin
          r_sel <= r_sel;
        end else if (!w_found) begin
          r_sel   <= '0;
          r_grant <= '0;
          r_valid <= 1'b0;
        end else begin
          r_sel   <= w_idx;
          r_grant <= ONE_OH << w_idx;
          r_valid <= 1'b1;
          if (L_MODE == RR) r_last <= w_idx;
        end
      end else begin
        r_multi <= 1'b0;
      end
    end
  end

  assign bus.sel_out        = r_sel;
  assign bus.grant_oh       = r_grant;
  assign bus.sel_valid      = r_valid;
  assign bus.multi_drive    = r_multi;
  assign bus.contention_err = r_err;
  assign bus.contention_cnt = r_cnt;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_source_arbiter
// Two arbiters share one stimulus stream: u_fix (MODE 0, CNT_W 8) and
// u_rr (MODE 1, CNT_W 2). Expected values are hand-computed per vector.
// ----------------------------------------------------------------------------
module tb_bus_source_arbiter;
  import bus_sel_pkg::*;

  logic        clock;
  logic        reset_n;
  logic [31:0] req;
  logic        sample;
  logic        lock;
  logic        err_clear;

  int n_vec;
  int n_err;

  bus_source_arbiter_if #(.N_SRC(32), .CNT_W(8)) if_fix ();
  bus_source_arbiter_if #(.N_SRC(32), .CNT_W(2)) if_rr  ();

  assign if_fix.req_in    = req;
  assign if_fix.sample    = sample;
  assign if_fix.lock      = lock;
  assign if_fix.err_clear = err_clear;
  assign if_rr.req_in     = req;
  assign if_rr.sample     = sample;
  assign if_rr.lock       = lock;
  assign if_rr.err_clear  = err_clear;

  bus_source_arbiter #(.N_SRC(32), .MODE(0), .CNT_W(8)) u_fix (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_fix)
  );

  bus_source_arbiter #(.N_SRC(32), .MODE(1), .CNT_W(2)) u_rr (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_rr)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One sampled edge; outputs are then read 1 ns after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = '0; sample = 1'b0; lock = 1'b0; err_clear = 1'b0;
    step(); step();
    n_vec++;
    if ({if_fix.sel_out, if_fix.grant_oh, if_fix.sel_valid, if_fix.multi_drive,
         if_fix.contention_err, if_fix.contention_cnt} !== 48'h0) begin
      n_err++;
      $display("FAIL reset_fix: got sel=%0d grant=%h v=%b md=%b err=%b cnt=%0d, want all 0",
               if_fix.sel_out, if_fix.grant_oh, if_fix.sel_valid, if_fix.multi_drive,
               if_fix.contention_err, if_fix.contention_cnt);
    end
    n_vec++;
    if ({if_rr.sel_out, if_rr.grant_oh, if_rr.sel_valid, if_rr.multi_drive,
         if_rr.contention_err, if_rr.contention_cnt} !== 42'h0) begin
      n_err++;
      $display("FAIL reset_rr: got sel=%0d grant=%h v=%b md=%b err=%b cnt=%0d, want all 0",
               if_rr.sel_out, if_rr.grant_oh, if_rr.sel_valid, if_rr.multi_drive,
               if_rr.contention_err, if_rr.contention_cnt);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_fixed_priority();
    req = (32'd1 << SRC_PC) | (32'd1 << SRC_R5); sample = 1'b1;
    step();
    n_vec++;
    if (if_fix.sel_out !== 5'd20 || if_fix.grant_oh !== 32'h0010_0000 ||
        if_fix.sel_valid !== 1'b1 || if_fix.multi_drive !== 1'b1 ||
        if_fix.contention_err !== 1'b1 || if_fix.contention_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL fixed_pc_r5: got sel=%0d grant=%h v=%b md=%b err=%b cnt=%0d, want 20 00100000 1 1 1 1",
               if_fix.sel_out, if_fix.grant_oh, if_fix.sel_valid, if_fix.multi_drive,
               if_fix.contention_err, if_fix.contention_cnt);
    end
    // round-robin from reset starts at index 0 -> bit 5 first
    n_vec++;
    if (if_rr.sel_out !== 5'd5 || if_rr.grant_oh !== 32'h0000_0020 ||
        if_rr.contention_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL rr_first_after_reset: got sel=%0d grant=%h cnt=%0d, want 5 00000020 1",
               if_rr.sel_out, if_rr.grant_oh, if_rr.contention_cnt);
    end
    req = 32'd1 << SRC_R3;
    step();
    n_vec++;
    if (if_fix.sel_out !== 5'd3 || if_fix.grant_oh !== 32'h0000_0008 ||
        if_fix.multi_drive !== 1'b0 || if_fix.contention_err !== 1'b1 ||
        if_fix.contention_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL fixed_single: got sel=%0d grant=%h md=%b err=%b cnt=%0d, want 3 00000008 0 1 1",
               if_fix.sel_out, if_fix.grant_oh, if_fix.multi_drive,
               if_fix.contention_err, if_fix.contention_cnt);
    end
  endtask

  task automatic test_empty_hold();
    req = '0; sample = 1'b1;
    step();
    n_vec++;
    if (if_fix.sel_valid !== 1'b0 || if_fix.sel_out !== 5'd0 || if_fix.grant_oh !== 32'h0 ||
        if_rr.sel_valid !== 1'b0 || if_rr.sel_out !== 5'd0 || if_rr.grant_oh !== 32'h0) begin
      n_err++;
      $display("FAIL empty: got fix v=%b sel=%0d grant=%h rr v=%b sel=%0d grant=%h, want all 0",
               if_fix.sel_valid, if_fix.sel_out, if_fix.grant_oh,
               if_rr.sel_valid, if_rr.sel_out, if_rr.grant_oh);
    end
    req = 32'd1 << SRC_R9; sample = 1'b0;
    step();
    n_vec++;
    if (if_fix.sel_valid !== 1'b0 || if_fix.sel_out !== 5'd0 || if_rr.sel_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_empty: got fix v=%b sel=%0d rr v=%b, want 0 0 0",
               if_fix.sel_valid, if_fix.sel_out, if_rr.sel_valid);
    end
    sample = 1'b1;
    step();
    n_vec++;
    if (if_fix.sel_out !== 5'd9 || if_rr.sel_out !== 5'd9 || if_rr.sel_valid !== 1'b1) begin
      n_err++;
      $display("FAIL grant_r9: got fix sel=%0d rr sel=%0d rr v=%b, want 9 9 1",
               if_fix.sel_out, if_rr.sel_out, if_rr.sel_valid);
    end
    req = (32'd1 << 12) | (32'd1 << 2); sample = 1'b0;
    step();
    n_vec++;
    if (if_fix.sel_out !== 5'd9 || if_fix.grant_oh !== 32'h0000_0200 ||
        if_fix.multi_drive !== 1'b0 || if_fix.contention_cnt !== 8'd1 ||
        if_rr.sel_out !== 5'd9 || if_rr.contention_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL hold_no_sample: got fix sel=%0d grant=%h md=%b cnt=%0d rr sel=%0d cnt=%0d, want 9 00000200 0 1 9 1",
               if_fix.sel_out, if_fix.grant_oh, if_fix.multi_drive, if_fix.contention_cnt,
               if_rr.sel_out, if_rr.contention_cnt);
    end
  endtask

  task automatic test_saturation_clear();
    err_clear = 1'b1; sample = 1'b0;
    step();
    n_vec++;
    if (if_fix.contention_err !== 1'b0 || if_fix.contention_cnt !== 8'd0 ||
        if_rr.contention_err !== 1'b0 || if_rr.contention_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL clear_no_sample: got fix err=%b cnt=%0d rr err=%b cnt=%0d, want 0 0 0 0",
               if_fix.contention_err, if_fix.contention_cnt,
               if_rr.contention_err, if_rr.contention_cnt);
    end
    err_clear = 1'b0; sample = 1'b1; req = 32'h0000_0006;
    for (int i = 0; i < 5; i++) step();
    n_vec++;
    if (if_rr.contention_cnt !== 2'd3 || if_rr.contention_err !== 1'b1 ||
        if_fix.contention_cnt !== 8'd5 || if_rr.multi_drive !== 1'b1) begin
      n_err++;
      $display("FAIL saturate: got rr cnt=%0d err=%b md=%b fix cnt=%0d, want 3 1 1 5",
               if_rr.contention_cnt, if_rr.contention_err, if_rr.multi_drive,
               if_fix.contention_cnt);
    end
    err_clear = 1'b1;
    step();
    n_vec++;
    if (if_rr.contention_cnt !== 2'd1 || if_rr.contention_err !== 1'b1 ||
        if_fix.contention_cnt !== 8'd1 || if_fix.contention_err !== 1'b1) begin
      n_err++;
      $display("FAIL clear_with_event: got rr cnt=%0d err=%b fix cnt=%0d err=%b, want 1 1 1 1",
               if_rr.contention_cnt, if_rr.contention_err,
               if_fix.contention_cnt, if_fix.contention_err);
    end
    err_clear = 1'b0; req = 32'd1 << SRC_R4;
    step();
    n_vec++;
    if (if_fix.multi_drive !== 1'b0 || if_fix.contention_cnt !== 8'd1 ||
        if_fix.sel_out !== 5'd4 || if_rr.multi_drive !== 1'b0 || if_rr.contention_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL single_after_clear: got fix md=%b cnt=%0d sel=%0d rr md=%b cnt=%0d, want 0 1 4 0 1",
               if_fix.multi_drive, if_fix.contention_cnt, if_fix.sel_out,
               if_rr.multi_drive, if_rr.contention_cnt);
    end
  endtask

  task automatic test_async_reset();
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({if_fix.sel_out, if_fix.grant_oh, if_fix.sel_valid, if_fix.multi_drive,
         if_fix.contention_err, if_fix.contention_cnt} !== 48'h0 ||
        {if_rr.sel_out, if_rr.grant_oh, if_rr.sel_valid, if_rr.multi_drive,
         if_rr.contention_err, if_rr.contention_cnt} !== 42'h0) begin
      n_err++;
      $display("FAIL async_reset: got fix sel=%0d v=%b cnt=%0d rr sel=%0d v=%b cnt=%0d, want all 0",
               if_fix.sel_out, if_fix.sel_valid, if_fix.contention_cnt,
               if_rr.sel_out, if_rr.sel_valid, if_rr.contention_cnt);
    end
    #1;
    reset_n = 1'b1;
    req = (32'd1 << 31) | 32'd1;
    step();
    n_vec++;
    if (if_rr.sel_out !== 5'd0 || if_rr.grant_oh !== 32'h0000_0001 ||
        if_rr.sel_valid !== 1'b1 || if_fix.sel_out !== 5'd31) begin
      n_err++;
      $display("FAIL rr_after_reset: got rr sel=%0d grant=%h v=%b fix sel=%0d, want 0 00000001 1 31",
               if_rr.sel_out, if_rr.grant_oh, if_rr.sel_valid, if_fix.sel_out);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_sel [4];
    exp_sel[0] = 5'd3; exp_sel[1] = 5'd7; exp_sel[2] = 5'd30; exp_sel[3] = 5'd3;
    req = (32'd1 << 3) | (32'd1 << 7) | (32'd1 << 30);
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if (if_rr.sel_out !== exp_sel[i] || if_rr.grant_oh !== (32'd1 << exp_sel[i]) ||
          if_fix.sel_out !== 5'd30 || if_rr.multi_drive !== 1'b1) begin
        n_err++;
        $display("FAIL rr_cycle%0d: got rr sel=%0d grant=%h md=%b fix sel=%0d, want %0d %h 1 30",
                 i, if_rr.sel_out, if_rr.grant_oh, if_rr.multi_drive, if_fix.sel_out,
                 exp_sel[i], 32'd1 << exp_sel[i]);
      end
    end
  endtask

  task automatic test_lock();
    req = (32'd1 << 3) | (32'd1 << 7); lock = 1'b0;
    step();
    n_vec++;
    if (if_rr.sel_out !== 5'd7) begin
      n_err++;
      $display("FAIL lock_setup: got rr sel=%0d, want 7", if_rr.sel_out);
    end
    lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (if_rr.sel_out !== 5'd7 || if_rr.sel_valid !== 1'b1 || if_rr.multi_drive !== 1'b1) begin
        n_err++;
        $display("FAIL lock_hold%0d: got rr sel=%0d v=%b md=%b, want 7 1 1",
                 i, if_rr.sel_out, if_rr.sel_valid, if_rr.multi_drive);
      end
    end
    req = 32'd1 << 3;
    step();
    n_vec++;
    if (if_rr.sel_out !== 5'd3 || if_rr.grant_oh !== 32'h0000_0008 ||
        if_fix.sel_out !== 5'd3 || if_rr.multi_drive !== 1'b0) begin
      n_err++;
      $display("FAIL lock_release: got rr sel=%0d grant=%h md=%b fix sel=%0d, want 3 00000008 0 3",
               if_rr.sel_out, if_rr.grant_oh, if_rr.multi_drive, if_fix.sel_out);
    end
    lock = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_fixed_priority();
    test_empty_hold();
    test_saturation_clear();
    test_async_reset();
    test_round_robin();
    test_lock();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
